fan_pwm_ramp: RTL and testbench

Tick-driven PWM generator with a soft-start/soft-stop duty ramp for the fan motor driver. It sits directly downstream of the clock divider. It consumes that block's single-cycle `tick` enable pulse and produces the motor PWM. Duty changes are slewed one LSB at a time at PWM-period boundaries, so speed changes never step the motor abruptly or glitch mid-period.

---
 rtl/fan_pkg.sv | 18 +
 rtl/pwm_counter.sv | 39 +++
 rtl/fan_pwm_ramp.sv | 90 +++++++++
 tb/tb_fan_pwm_ramp.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared state encoding, defaults and sizing helpers for the fan PWM ramp.
package fan_pkg;

  localparam int unsigned DEF_RES_BITS = 8;
  localparam int unsigned DEF_RAMP_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } fan_state_e;

  // Width of the period-per-step counter; a divide of 1 still needs one bit.
  function automatic int unsigned ramp_cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// Tick-gated PWM phase counter, duty compare and period-start pulse.
module pwm_counter
  import fan_pkg::*;
#(
  parameter int unsigned RES_BITS = DEF_RES_BITS
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                tick,
  input  logic [RES_BITS-1:0] duty_next,
  output logic                wrap_c,
  output logic                pwm_out,
  output logic                period_start
);

  localparam logic [RES_BITS-1:0] CNT_MAX = '1;

  logic [RES_BITS-1:0] cnt;
  logic [RES_BITS-1:0] cnt_next_c;

  assign cnt_next_c = cnt + RES_BITS'(1);
  assign wrap_c     = tick && (cnt == CNT_MAX);

  // Compare against the post-tick phase and duty so output and duty change together.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt          <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap_c;
      if (tick) begin
        cnt     <= cnt_next_c;
        pwm_out <= (cnt_next_c < duty_next);
      end
    end
  end

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan PWM with soft-start/soft-stop: duty slews one LSB every RAMP_DIV periods.
module fan_pwm_ramp
  import fan_pkg::*;
#(
  parameter int unsigned RES_BITS = DEF_RES_BITS,
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                tick,
  input  logic [RES_BITS-1:0] target_duty,
  input  logic                target_valid,
  output logic                pwm_out,
  output logic [RES_BITS-1:0] cur_duty,
  output logic                busy,
  output logic                period_start
);

  localparam int unsigned     RC_W    = ramp_cnt_width(RAMP_DIV);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_DIV - 1);

  logic [RES_BITS-1:0] target;
  logic [RES_BITS-1:0] duty_next_c;
  logic [RC_W-1:0]     ramp_cnt;
  logic [RC_W-1:0]     ramp_next_c;
  fan_state_e          state;
  fan_state_e          state_next_c;
  logic                wrap_c;

  pwm_counter #(
    .RES_BITS (RES_BITS)
  ) u_pwm_counter (
    .clk          (clk),
    .reset_p      (reset_p),
    .tick         (tick),
    .duty_next    (duty_next_c),
    .wrap_c       (wrap_c),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  // Boundary stepping; the target compare guards against overshoot during reversals.
  always_comb begin
    duty_next_c = cur_duty;
    ramp_next_c = ramp_cnt;
    if (state == ST_IDLE) begin
      ramp_next_c = '0;
    end else if (wrap_c) begin
      if (ramp_cnt == RC_LAST) begin
        ramp_next_c = '0;
        if ((state == ST_UP) && (cur_duty < target)) begin
          duty_next_c = cur_duty + RES_BITS'(1);
        end else if ((state == ST_DOWN) && (cur_duty > target)) begin
          duty_next_c = cur_duty - RES_BITS'(1);
        end
      end else begin
        ramp_next_c = ramp_cnt + RC_W'(1);
      end
    end
  end

  // Direction follows the latched target every clk, including direct reversals.
  always_comb begin
    state_next_c = ST_IDLE;
    if (target > cur_duty) begin
      state_next_c = ST_UP;
    end else if (target < cur_duty) begin
      state_next_c = ST_DOWN;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      target   <= '0;
      cur_duty <= '0;
      ramp_cnt <= '0;
      state    <= ST_IDLE;
      busy     <= 1'b0;
    end else begin
      if (target_valid) begin
        target <= target_duty;
      end
      cur_duty <= duty_next_c;
      ramp_cnt <= ramp_next_c;
      state    <= state_next_c;
      busy     <= (state_next_c != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Randomized and directed checks of fan_pwm_ramp against a behavioural duty/PWM model.
module tb_fan_pwm_ramp;

  localparam int RB  = 8;
  localparam int RD  = 2;
  localparam int PER = 256;

  logic          clk = 1'b0;
  logic          reset_p;
  logic          tick;
  logic [RB-1:0] target_duty;
  logic          target_valid;
  logic          pwm_out;
  logic [RB-1:0] cur_duty;
  logic          busy;
  logic          period_start;
  logic [RB+2:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: PWM phase, applied duty, latched target, periods since step, direction sign.
  int m_cnt, m_duty, m_target, m_rc, m_dir;
  bit m_pwm, m_ps;

  fan_pwm_ramp #(.RES_BITS(RB), .RAMP_DIV(RD)) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .tick         (tick),
    .target_duty  (target_duty),
    .target_valid (target_valid),
    .pwm_out      (pwm_out),
    .cur_duty     (cur_duty),
    .busy         (busy),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  assign obs = {pwm_out, period_start, busy, cur_duty};

  function automatic logic [RB+2:0] exp_vec();
    return {m_pwm, m_ps, 1'(m_dir != 0), RB'(m_duty)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_target = 0; m_rc = 0; m_dir = 0; m_pwm = 0; m_ps = 0;
  endtask

  task automatic model_step(input bit t, input bit v, input int d);
    int nd, nrc, ndir;
    bit wrap;
    wrap = t && (m_cnt == PER - 1);
    nd   = m_duty;
    nrc  = m_rc;
    if (m_dir == 0) nrc = 0;
    else if (wrap) begin
      if (m_rc == RD - 1) begin
        nrc = 0;
        if (m_dir > 0 && m_duty < m_target) nd = m_duty + 1;
        else if (m_dir < 0 && m_duty > m_target) nd = m_duty - 1;
      end else nrc = m_rc + 1;
    end
    ndir = (m_target > m_duty) ? 1 : ((m_target < m_duty) ? -1 : 0);
    m_ps = wrap;
    if (t) begin
      m_cnt = (m_cnt + 1) % PER;
      m_pwm = (m_cnt < nd);
    end
    m_duty = nd;
    m_rc   = nrc;
    m_dir  = ndir;
    if (v) m_target = d;
  endtask

  task automatic step(input bit t, input bit v, input int d);
    tick = t; target_valid = v; target_duty = RB'(d);
    model_step(t, v, d);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    int ps_n, hi;
    ps_n = 0; hi = 0;
    reset_p = 1'b1; tick = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== '0) begin n_bad++; $display("FAIL reset_hold got %h want 0", obs); end
    end
    model_reset();
    reset_p = 1'b0;
    repeat (3 * PER) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      ps_n += int'(period_start);
      hi   += int'(pwm_out);
    end
    n_cmp++;
    if (ps_n != 3) begin n_bad++; $display("FAIL reset_period_pulses got %0d want 3", ps_n); end
    n_cmp++;
    if (hi != 0) begin n_bad++; $display("FAIL reset_pwm_low got %0d high clks want 0", hi); end
  endtask

  task automatic test_ramp_up();
    int vals[$];
    int at[$];
    int prev, hi;
    step(1, 1, 4);
    step(1, 0, 0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL ramp_busy_rise got %b want 1", busy); end
    prev = int'(cur_duty);
    for (int i = 0; i < 3000 && !(m_duty == 4 && m_dir == 0); i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL ramp_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (int'(cur_duty) != prev) begin
        prev = int'(cur_duty);
        vals.push_back(prev);
        at.push_back(cyc);
      end
    end
    n_cmp++;
    if (vals.size() != 4) begin n_bad++; $display("FAIL ramp_step_count got %0d want 4", vals.size()); end
    for (int i = 0; i < vals.size() && i < 4; i++) begin
      n_cmp++;
      if (vals[i] != i + 1) begin n_bad++; $display("FAIL ramp_step_value idx=%0d got %0d want %0d", i, vals[i], i + 1); end
      if (i > 0) begin
        n_cmp++;
        if (at[i] - at[i-1] != RD * PER) begin
          n_bad++; $display("FAIL ramp_step_spacing idx=%0d got %0d want %0d", i, at[i] - at[i-1], RD * PER);
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ramp_busy_fall got %b want 0", busy); end
    hi = 0;
    repeat (PER) begin
      step(1, 0, 0);
      hi += int'(pwm_out);
    end
    n_cmp++;
    if (hi != 4) begin n_bad++; $display("FAIL ramp_steady_high got %0d want 4", hi); end
  endtask

  task automatic test_tick_gap();
    int ph, hi;
    bit t, seen;
    logic pp;
    logic [RB-1:0] pd;
    ph = 0; hi = 0; seen = 0;
    step(1, 1, 10);
    for (int i = 0; i < 40000 && !(m_duty == 10 && m_dir == 0); i++) begin
      t = (ph % 3 == 0); ph++;
      pp = pwm_out; pd = cur_duty;
      step(t, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL gap_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (!t) begin
        n_cmp++;
        if ({pwm_out, cur_duty} !== {pp, pd}) begin
          n_bad++; $display("FAIL gap_hold cyc=%0d got %b/%0d want %b/%0d", cyc, pwm_out, cur_duty, pp, pd);
        end
      end
    end
    n_cmp++;
    if (!(m_duty == 10 && m_dir == 0)) begin n_bad++; $display("FAIL gap_settle_timeout got duty %0d want 10", m_duty); end
    for (int i = 0; i < 1000 && !seen; i++) begin
      t = (ph % 3 == 0); ph++;
      step(t, 0, 0);
      if (period_start === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL gap_period_timeout got no period_start want pulse"); end
    hi = int'(pwm_out);
    repeat (3 * PER - 1) begin
      t = (ph % 3 == 0); ph++;
      step(t, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL gap_period_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      hi += int'(pwm_out);
    end
    n_cmp++;
    if (hi != 30) begin n_bad++; $display("FAIL gap_high_clks got %0d want 30", hi); end
  endtask

  task automatic test_reversal();
    int mx, last;
    bit rose;
    step(1, 1, 0);
    for (int i = 0; i < 8000 && !(m_duty == 0 && m_dir == 0); i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rev_down_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    step(1, 1, 20);
    for (int i = 0; i < 8000 && m_duty != 8; i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rev_up_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++;
    if (cur_duty !== 8'd8) begin n_bad++; $display("FAIL rev_reach8 got %0d want 8", cur_duty); end
    step(1, 1, 3);
    mx = int'(cur_duty); last = mx; rose = 0;
    for (int i = 0; i < 8000 && !(m_duty == 3 && m_dir == 0); i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rev_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (int'(cur_duty) > last) rose = 1;
      if (int'(cur_duty) > mx) mx = int'(cur_duty);
      last = int'(cur_duty);
    end
    n_cmp++;
    if (mx > 8 || rose) begin n_bad++; $display("FAIL rev_no_overshoot got max %0d want <= 8", mx); end
    n_cmp++;
    if ({busy, cur_duty} !== {1'b0, 8'd3}) begin n_bad++; $display("FAIL rev_final got busy=%b duty=%0d want busy=0 duty=3", busy, cur_duty); end
  endtask

  task automatic test_coincident();
    bit found;
    found = 0;
    step(1, 1, 6);
    for (int i = 0; i < 3000 && m_duty != 4; i++) step(1, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      if (m_cnt == PER - 1 && m_rc == RD - 1 && m_dir > 0) begin found = 1; break; end
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL coinc_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL coinc_align_timeout got none want step boundary"); end
    step(1, 1, 0);
    n_cmp++;
    if (cur_duty !== 8'd5) begin n_bad++; $display("FAIL coinc_old_target got %0d want 5", cur_duty); end
    found = 0;
    for (int i = 0; i < 1500; i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL coinc_after_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (cur_duty !== 8'd5) begin found = 1; break; end
    end
    n_cmp++;
    if (!found || cur_duty !== 8'd4) begin n_bad++; $display("FAIL coinc_new_target got %0d want 4", cur_duty); end
  endtask

  task automatic test_reset_mid_ramp();
    bit hi_seen;
    hi_seen = 0;
    step(1, 1, 12);
    for (int i = 0; i < 8000 && m_duty != 12; i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rst_ramp_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    for (int i = 0; i < 300; i++) begin
      if (pwm_out === 1'b1) begin hi_seen = 1; break; end
      step(1, 0, 0);
    end
    n_cmp++;
    if (!hi_seen || cur_duty !== 8'd12) begin n_bad++; $display("FAIL rst_setup got pwm=%b duty=%0d want pwm=1 duty=12", pwm_out, cur_duty); end
    reset_p = 1'b1;
    #1;
    n_cmp++;
    if ({pwm_out, cur_duty, busy} !== '0) begin
      n_bad++; $display("FAIL rst_async got pwm=%b duty=%0d busy=%b want all 0", pwm_out, cur_duty, busy);
    end
    repeat (2) begin @(posedge clk); #1; end
    reset_p = 1'b0;
    model_reset();
    repeat (2 * PER) begin
      step(1, 0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rst_after_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++;
    if ({busy, cur_duty} !== '0) begin n_bad++; $display("FAIL rst_target_cleared got busy=%b duty=%0d want 0/0", busy, cur_duty); end
  endtask

  task automatic test_random();
    bit t, v;
    int d;
    repeat (6000) begin
      t = ($urandom % 2) == 0;
      v = ($urandom % 150) == 0;
      d = int'($urandom % 12);
      step(t, v, d);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL random_model cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  initial begin
    reset_p = 1'b1; tick = 1'b0; target_valid = 1'b0; target_duty = '0;
    model_reset();
    test_reset();
    test_ramp_up();
    test_tick_gap();
    test_reversal();
    test_coincident();
    test_reset_mid_ramp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
